// File: rtl/loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : loader_pkg
// Brief   : Shared types and constants for the instruction-memory loader.
// Revision: 1.0 - initial release
// ============================================================================
package loader_pkg;

  // Loader life cycle. IDLE after reset, LOAD while accepting host words,
  // FILL while zeroing the tail, DONE once the CPU may run, ERR on overflow.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    FILL = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } loader_state_t;

  // Native machine-code word width of the target CPU.
  localparam int MACH_W = 9;

endpackage
`default_nettype wire

// File: rtl/program_loader.sv
`default_nettype none
// ============================================================================
// Module  : program_loader
// Brief   : Streams host machine-code words sequentially from address 0 into
//           a writable instruction memory, optionally zero-fills the unused
//           tail, holds the CPU off while loading and pulses cpu_start once
//           the program is in place.
// Revision: 1.0 - initial release
// ============================================================================
module program_loader
  import loader_pkg::*;
#(
  parameter int D         = 12,
  parameter int W         = MACH_W,
  parameter bit ZERO_FILL = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load_req,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         mem_we,
  output logic [D-1:0] mem_addr,
  output logic [W-1:0] mem_wdata,
  output logic         cpu_hold,
  output logic         cpu_start,
  output logic         load_done,
  output logic         load_err,
  output logic [D:0]   word_count,
  output logic [W-1:0] checksum
);

  // Highest memory address; reaching it ends LOAD or FILL.
  localparam logic [D-1:0] ADDR_MAX = {D{1'b1}};

  loader_state_t state_q, state_d;

  logic [D-1:0] addr_q, addr_d;
  logic [D:0]   word_count_q, word_count_d;
  logic [W-1:0] checksum_q, checksum_d;
  logic         mem_we_q, mem_we_d;
  logic [D-1:0] mem_addr_q, mem_addr_d;
  logic [W-1:0] mem_wdata_q, mem_wdata_d;
  logic         cpu_hold_q, cpu_hold_d;
  logic         cpu_start_q, cpu_start_d;
  logic         load_done_q, load_done_d;
  logic         load_err_q, load_err_d;

  logic         ready_w;
  logic         handshake_w;
  logic         at_max_w;

  // Ready depends on state only so the host can never form a combinational loop.
  assign ready_w     = (state_q == LOAD);
  assign handshake_w = in_valid & ready_w;
  assign at_max_w    = (addr_q == ADDR_MAX);

  // State and datapath registers; reset aborts any load in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      word_count_q <= '0;
      checksum_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      cpu_start_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      word_count_q <= word_count_d;
      checksum_q   <= checksum_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      cpu_start_q  <= cpu_start_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  // Next-state: the address of the accepted word decides how LOAD exits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_req) state_d = LOAD;
      end
      LOAD: begin
        if (handshake_w) begin
          if (in_last) begin
            if (at_max_w || !ZERO_FILL) state_d = DONE;
            else                        state_d = FILL;
          end else if (at_max_w) begin
            state_d = ERR;
          end
        end
      end
      FILL: begin
        if (at_max_w) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and status updates; status flags change on entry to DONE/ERR.
  always_comb begin
    addr_d       = addr_q;
    word_count_d = word_count_q;
    checksum_d   = checksum_q;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    cpu_start_d  = 1'b0;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (load_req) begin
          addr_d       = '0;
          word_count_d = '0;
          checksum_d   = '0;
          load_done_d  = 1'b0;
          load_err_d   = 1'b0;
          cpu_hold_d   = 1'b1;
        end
      end
      LOAD: begin
        if (handshake_w) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = addr_q;
          mem_wdata_d  = in_data;
          word_count_d = word_count_q + (D+1)'(1);
          checksum_d   = checksum_q ^ in_data;
          // The address saturates at the top; the exit rules stop further use.
          if (!at_max_w) addr_d = addr_q + D'(1);
        end
      end
      FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = addr_q;
        mem_wdata_d = '0;
        if (!at_max_w) addr_d = addr_q + D'(1);
      end
      default: ;
    endcase

    if ((state_d == DONE) && (state_q != DONE)) begin
      cpu_start_d = 1'b1;
      load_done_d = 1'b1;
      cpu_hold_d  = 1'b0;
    end
    if ((state_d == ERR) && (state_q != ERR)) begin
      load_err_d = 1'b1;
      cpu_hold_d = 1'b1;
    end
  end

  assign in_ready   = ready_w;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign cpu_start  = cpu_start_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign word_count = word_count_q;
  assign checksum   = checksum_q;

endmodule
`default_nettype wire
